// File: rtl/fc_layer_tiled.sv
// Tiled fully-connected layer: NUM_PE MAC lanes sweep OUT_SIZE neurons in batches, one input element per cycle.
// Optional FC_SAT_FLAG_EN adds a sticky sat_flag output reporting any clamped output of the last run.
module fc_layer_tiled #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 10,
  parameter int W        = 8,
  parameter int NUM_PE   = 5,
  parameter int SHIFT    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         relu_en,
  input  logic [W*IN_SIZE-1:0]          in_vector_flat,
  input  logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat,
  input  logic [W*OUT_SIZE-1:0]         biases_flat,
  output logic [W*OUT_SIZE-1:0]         out_vector_flat,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   fsm_state
`ifdef FC_SAT_FLAG_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int ACC_WIDTH = 2*W + $clog2(IN_SIZE) + SHIFT + 1;
  localparam int NBATCH    = (OUT_SIZE + NUM_PE - 1) / NUM_PE;
  localparam int K_W       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int B_W       = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((2**(W-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ACC_WIDTH'(-(2**(W-1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t state, state_next;

  logic [W*IN_SIZE-1:0]          x_reg;
  logic                          relu_reg;
  logic [K_W-1:0]                k;
  logic [B_W-1:0]                b;
  logic signed [ACC_WIDTH-1:0]   acc       [NUM_PE];
  logic signed [W-1:0]           x_cur;
  logic signed [W-1:0]           w_lane    [NUM_PE];
  logic signed [2*W-1:0]         prod_lane [NUM_PE];
  logic signed [ACC_WIDTH-1:0]   bias_load [NUM_PE];
  logic signed [ACC_WIDTH-1:0]   y_full    [NUM_PE];
  logic signed [W-1:0]           y_lane    [NUM_PE];
  logic                          accept;
  logic                          last_k;
  logic                          last_b;
  int                            nb;
`ifdef FC_SAT_FLAG_EN
  logic [NUM_PE-1:0]             clamp_lane;
`endif

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last_k = (k == K_W'(IN_SIZE - 1));
  assign last_b = (b == B_W'(NBATCH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_MAC;
      S_MAC:          if (last_k) state_next = S_WB;
      S_WB:           state_next = last_b ? S_DONE : S_MAC;
      default:        state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == S_MAC) || (state == S_WB);
    done      = (state == S_DONE);
    fsm_state = state;
  end

  // Per-lane datapath; lanes past OUT_SIZE in the last batch see zero operands and are never written back.
  always_comb begin
    x_cur = x_reg[k*W +: W];
    nb    = (state == S_WB) ? int'(b) + 1 : 0;
`ifdef FC_SAT_FLAG_EN
    clamp_lane = '0;
`endif
    for (int j = 0; j < NUM_PE; j++) begin
      w_lane[j]    = '0;
      bias_load[j] = '0;
      if (int'(b)*NUM_PE + j < OUT_SIZE)
        w_lane[j] = weights_flat[((int'(b)*NUM_PE + j)*IN_SIZE + int'(k))*W +: W];
      if (nb*NUM_PE + j < OUT_SIZE)
        bias_load[j] = ACC_WIDTH'($signed(biases_flat[(nb*NUM_PE + j)*W +: W])) <<< SHIFT;
      prod_lane[j] = (2*W)'(w_lane[j]) * (2*W)'(x_cur);
      y_full[j]    = acc[j] >>> SHIFT;
      if (relu_reg && y_full[j] < 0) y_full[j] = '0;
      y_lane[j] = y_full[j][W-1:0];
      if (y_full[j] > Y_MAX) begin
        y_lane[j] = Y_MAX[W-1:0];
`ifdef FC_SAT_FLAG_EN
        if (int'(b)*NUM_PE + j < OUT_SIZE) clamp_lane[j] = 1'b1;
`endif
      end else if (y_full[j] < Y_MIN) begin
        y_lane[j] = Y_MIN[W-1:0];
`ifdef FC_SAT_FLAG_EN
        if (int'(b)*NUM_PE + j < OUT_SIZE) clamp_lane[j] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg           <= '0;
      relu_reg        <= 1'b0;
      k               <= '0;
      b               <= '0;
      out_vector_flat <= '0;
      for (int j = 0; j < NUM_PE; j++) acc[j] <= '0;
`ifdef FC_SAT_FLAG_EN
      sat_flag        <= 1'b0;
`endif
    end else if (accept) begin
      x_reg           <= in_vector_flat;
      relu_reg        <= relu_en;
      k               <= '0;
      b               <= '0;
      out_vector_flat <= '0;
      for (int j = 0; j < NUM_PE; j++) acc[j] <= bias_load[j];
`ifdef FC_SAT_FLAG_EN
      sat_flag        <= 1'b0;
`endif
    end else if (state == S_MAC) begin
      for (int j = 0; j < NUM_PE; j++) acc[j] <= acc[j] + ACC_WIDTH'(prod_lane[j]);
      k <= last_k ? '0 : k + K_W'(1);
    end else if (state == S_WB) begin
      for (int n = 0; n < OUT_SIZE; n++)
        if (b == B_W'(n / NUM_PE)) out_vector_flat[n*W +: W] <= y_lane[n % NUM_PE];
      // Reload the lanes with the next batch's biases in the same edge so MAC restarts without a gap.
      for (int j = 0; j < NUM_PE; j++) acc[j] <= bias_load[j];
      k <= '0;
      b <= last_b ? '0 : b + B_W'(1);
`ifdef FC_SAT_FLAG_EN
      sat_flag <= sat_flag | (|clamp_lane);
`endif
    end
  end

endmodule

// File: tb/tb_fc_layer_tiled.sv
// Bench for fc_layer_tiled: two instances (5 lanes/no shift, 3 lanes/shift 4) driven with shared stimulus,
// checked by per-instance scoreboards against an integer reference model.
module tb_fc_layer_tiled;
  localparam int IN_SIZE  = 16;
  localparam int OUT_SIZE = 10;
  localparam int W        = 8;
  localparam int PE_A     = 5;
  localparam int SH_A     = 0;
  localparam int PE_B     = 3;
  localparam int SH_B     = 4;
  localparam int OW       = W*OUT_SIZE;
  localparam int LAT_A    = ((OUT_SIZE + PE_A - 1) / PE_A) * (IN_SIZE + 1);
  localparam int LAT_B    = ((OUT_SIZE + PE_B - 1) / PE_B) * (IN_SIZE + 1);
  localparam int RND      = 1000;
  localparam longint MAXV = (2**(W-1)) - 1;
  localparam longint MINV = -(2**(W-1));

  logic                         clk, reset, start, relu_en;
  logic [W*IN_SIZE-1:0]          in_vector_flat;
  logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat;
  logic [OW-1:0]                 biases_flat;
  logic [OW-1:0]                 out_a, out_b;
  logic                         busy_a, busy_b, done_a, done_b;
  logic [1:0]                   state_a, state_b;
`ifdef FC_SAT_FLAG_EN
  logic                         sat_a, sat_b;
  bit                           sat_q_a[$], sat_q_b[$];
`endif

  logic signed [W-1:0] x_arr [IN_SIZE];
  logic signed [W-1:0] w_arr [OUT_SIZE][IN_SIZE];
  logic signed [W-1:0] b_arr [OUT_SIZE];
  logic [OW-1:0]       exp_q_a[$], exp_q_b[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  e0 = 0;
  int  bcnt_a = 0, bcnt_b = 0;
  bit  prev_a = 0, prev_b = 0;

  fc_layer_tiled #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .NUM_PE(PE_A), .SHIFT(SH_A)) dut_a (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .in_vector_flat(in_vector_flat), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_vector_flat(out_a), .busy(busy_a), .done(done_a), .fsm_state(state_a)
`ifdef FC_SAT_FLAG_EN
    , .sat_flag(sat_a)
`endif
  );

  fc_layer_tiled #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .NUM_PE(PE_B), .SHIFT(SH_B)) dut_b (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .in_vector_flat(in_vector_flat), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_vector_flat(out_b), .busy(busy_b), .done(done_b), .fsm_state(state_b)
`ifdef FC_SAT_FLAG_EN
    , .sat_flag(sat_b)
`endif
  );

  // Clock and cycle counter
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: y = floor((bias*2^s + sum x*w) / 2^s), optional ReLU, clamp to the W-bit signed range.
  function automatic logic [OW-1:0] model(input int shift, input bit relu, output bit sat);
    logic [OW-1:0] r;
    longint acc, y;
    r   = '0;
    sat = 0;
    for (int n = 0; n < OUT_SIZE; n++) begin
      acc = longint'(b_arr[n]) * (longint'(1) << shift);
      for (int k = 0; k < IN_SIZE; k++) acc += longint'(x_arr[k]) * longint'(w_arr[n][k]);
      y = acc >>> shift;
      if (relu && y < 0) y = 0;
      if (y > MAXV) begin y = MAXV; sat = 1; end
      else if (y < MINV) begin y = MINV; sat = 1; end
      r[n*W +: W] = y[W-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [W-1:0] pick(input int v);
    if (v == RND) return W'($urandom_range(0, (1 << W) - 1));
    return W'(v);
  endfunction

  task automatic fill(input int xv, input int wv, input int bv);
    for (int k = 0; k < IN_SIZE; k++) x_arr[k] = pick(xv);
    for (int n = 0; n < OUT_SIZE; n++) begin
      b_arr[n] = pick(bv);
      for (int k = 0; k < IN_SIZE; k++) w_arr[n][k] = pick(wv);
    end
  endtask

  task automatic pack_inputs();
    for (int k = 0; k < IN_SIZE; k++) in_vector_flat[k*W +: W] = x_arr[k];
    for (int n = 0; n < OUT_SIZE; n++) begin
      biases_flat[n*W +: W] = b_arr[n];
      for (int k = 0; k < IN_SIZE; k++) weights_flat[(n*IN_SIZE + k)*W +: W] = w_arr[n][k];
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic issue_start(input bit relu);
    @(negedge clk);
    start   = 1;
    relu_en = relu;
    @(negedge clk);
    start   = 0;
    relu_en = 1'($urandom_range(0, 1));
    e0      = cyc;
    cmp_int("accept_flags", {busy_a, busy_b, done_a, done_b}, 4'b1100);
    cmp("accept_clear_a", out_a, '0);
    cmp("accept_clear_b", out_b, '0);
  endtask

  // Driver: pushes the expected result, starts a run and waits (bounded) for both instances to finish.
  task automatic run(input bit relu, input bit pulse, input bit partial);
    logic [OW-1:0] ea, eb, pa, pb;
    bit sa, sb;
    pack_inputs();
    ea = model(SH_A, relu, sa);
    eb = model(SH_B, relu, sb);
    exp_q_a.push_back(ea);
    exp_q_b.push_back(eb);
`ifdef FC_SAT_FLAG_EN
    sat_q_a.push_back(sa);
    sat_q_b.push_back(sb);
`endif
    issue_start(relu);
    for (int i = 0; i < LAT_B + 20; i++) begin
      @(negedge clk);
      if (pulse) begin
        start   = (i == 10);
        relu_en = ~relu;
      end
      if (partial && cyc == e0 + IN_SIZE + 1) begin
        pa = ea;
        pb = eb;
        for (int n = 0; n < OUT_SIZE; n++) begin
          if (n >= PE_A) pa[n*W +: W] = '0;
          if (n >= PE_B) pb[n*W +: W] = '0;
        end
        cmp("batch0_a", out_a, pa);
        cmp("batch0_b", out_b, pb);
      end
      if (done_a && done_b) break;
    end
    start = 0;
    if (!(done_a && done_b)) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: done_a=%0b done_b=%0b required 1 1", done_a, done_b);
      do_reset();
      exp_q_a.delete();
      exp_q_b.delete();
`ifdef FC_SAT_FLAG_EN
      sat_q_a.delete();
      sat_q_b.delete();
`endif
    end
  endtask

  // Starts a run and resets it at E0+20; nothing is expected from the aborted run.
  task automatic abort_run();
    pack_inputs();
    issue_start(1'($urandom_range(0, 1)));
    while (cyc < e0 + 19) @(negedge clk);
    reset = 1;
    @(negedge clk);
    cmp("abort_out_a", out_a, '0);
    cmp("abort_out_b", out_b, '0);
    cmp_int("abort_flags", {busy_a, busy_b, done_a, done_b}, 0);
`ifdef FC_SAT_FLAG_EN
    cmp_int("abort_sat", {sat_a, sat_b}, 0);
`endif
    reset = 0;
  endtask

  // Monitor / scoreboard: compares on each rising done, independently of the driver.
  always @(negedge clk) begin
    if (reset) begin
      prev_a = 0; prev_b = 0; bcnt_a = 0; bcnt_b = 0;
    end else begin
      if (busy_a) bcnt_a++;
      if (busy_b) bcnt_b++;
      if (done_a && !prev_a) begin
        if (exp_q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_done: got done with empty queue, required no done");
        end else begin
          cmp("a_out", out_a, exp_q_a.pop_front());
          cmp_int("a_latency", cyc - e0, LAT_A);
          cmp_int("a_busy_cycles", bcnt_a, LAT_A);
`ifdef FC_SAT_FLAG_EN
          cmp_int("a_sat", sat_a, sat_q_a.pop_front());
`endif
        end
        bcnt_a = 0;
      end
      if (done_b && !prev_b) begin
        if (exp_q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_done: got done with empty queue, required no done");
        end else begin
          cmp("b_out", out_b, exp_q_b.pop_front());
          cmp_int("b_latency", cyc - e0, LAT_B);
          cmp_int("b_busy_cycles", bcnt_b, LAT_B);
`ifdef FC_SAT_FLAG_EN
          cmp_int("b_sat", sat_b, sat_q_b.pop_front());
`endif
        end
        bcnt_b = 0;
      end
      prev_a = done_a;
      prev_b = done_b;
    end
  end

  initial begin
    reset = 1; start = 0; relu_en = 0;
    in_vector_flat = '0; weights_flat = '0; biases_flat = '0;
    repeat (3) @(negedge clk);
    cmp("reset_out_a", out_a, '0);
    cmp("reset_out_b", out_b, '0);
    cmp_int("reset_flags", {busy_a, busy_b, done_a, done_b}, 0);
    cmp_int("reset_state", {state_a, state_b}, 0);
    reset = 0;

    fill(1, 1, 0);         run(1, 0, 1);
    fill(127, 127, 127);   run(1, 0, 0);
    fill(0, 127, 0);       run(1, 0, 0);
    fill(1, -1, -4);       run(0, 0, 0);
                           run(1, 0, 0);
    fill(127, -128, -4);   run(0, 0, 0);
    fill(4, 4, 2);         run(0, 0, 0);
    fill(0, RND, 0);
    for (int n = 0; n < OUT_SIZE; n++) b_arr[n] = W'(n);
    run(0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      fill(RND, RND, RND);
      run(1'($urandom_range(0, 1)), i == 2, 1'($urandom_range(0, 1)));
    end

    fill(RND, RND, RND);
    abort_run();
    fill(RND, RND, RND);
    run(1'($urandom_range(0, 1)), 0, 1);

    repeat (3) @(negedge clk);
    cmp_int("queue_a_drained", exp_q_a.size(), 0);
    cmp_int("queue_b_drained", exp_q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
